// File: rtl/link_uart.sv
// Memory-mapped UART at FF01 (SB data) / FF02 (SC control/status), fixed-divider baud timing.
// Define LINK_UART_RX_EN to build the receiver, its FIFO, rx_avail and overrun; otherwise TX only.
module link_uart #(
    parameter int BAUD_DIV = 36,
    parameter int RX_DEPTH = 4
) (
    input  logic        clockgb,
    input  logic        resetn,
    input  logic [15:0] address,
    input  logic [7:0]  indata,
    output logic [7:0]  outdata,
    input  logic        load,
    input  logic        store,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        irq
);
    localparam logic [11:0] BIT_LAST = 12'(BAUD_DIV - 1);

    // Bus handshake: store is a one-cycle write strobe taken on the next clock edge; load is a
    // level read (outdata combinational) and its rising edge at SB is the single FIFO pop event.
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
`ifdef LINK_UART_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef struct packed { tx_state_t tx; rx_state_t rx; } fsm_state_t;
`else
    typedef struct packed { tx_state_t tx; } fsm_state_t;
`endif

    fsm_state_t  state_q, state_d;
    logic        sel_sb, sel_sc, sb_wr, sc_wr, busy;
    logic [7:0]  tx_data, tx_shift, tx_shift_d;
    logic [11:0] tx_cnt, tx_cnt_d;
    logic [2:0]  tx_bit, tx_bit_d;
    logic        tx_line, tx_line_d, tx_done, irq_d;

    assign sel_sb = (address == 16'hFF01);
    assign sel_sc = (address == 16'hFF02);
    assign sb_wr  = store && sel_sb;
    assign sc_wr  = store && sel_sc;
    assign busy   = (state_q.tx != TX_IDLE);
    assign UART_TX = tx_line;

`ifdef LINK_UART_RX_EN
    localparam logic [11:0] HALF = 12'(BAUD_DIV / 2);
    localparam int PW = $clog2(RX_DEPTH);
    localparam int CW = PW + 1;

    logic          rx_s1, rx_s2, rx_d, load_d, overrun;
    logic [11:0]   rx_cnt, rx_cnt_d;
    logic [2:0]    rx_bit, rx_bit_d;
    logic [7:0]    rx_shift, rx_shift_d;
    logic          rx_push, push_ok, pop, full, ovr_set, rx_avail;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] rx_count;
    logic [7:0]    rx_mem [RX_DEPTH];

    assign rx_avail = (rx_count != '0);
    assign full     = (rx_count == CW'(RX_DEPTH));
    assign pop      = load && !load_d && sel_sb && rx_avail;
    assign push_ok  = rx_push && (!full || pop);
    assign ovr_set  = rx_push && full && !pop;
    assign irq_d    = tx_done | push_ok;
`else
    logic unused_rx;
    assign unused_rx = UART_RX;
    assign irq_d     = tx_done;
`endif

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_done    = 1'b0;
        case (state_q.tx)
            TX_IDLE: if (sc_wr && indata[7]) begin
                state_d.tx = TX_START;
                tx_shift_d = tx_data;
                tx_cnt_d   = '0;
            end
            TX_START: if (tx_cnt == BIT_LAST) begin
                state_d.tx = TX_DATA;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
            end else tx_cnt_d = tx_cnt + 12'd1;
            TX_DATA: if (tx_cnt == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_shift_d = {1'b0, tx_shift[7:1]};
                if (tx_bit == 3'd7) state_d.tx = TX_STOP;
                else tx_bit_d = tx_bit + 3'd1;
            end else tx_cnt_d = tx_cnt + 12'd1;
            TX_STOP: if (tx_cnt == BIT_LAST) begin
                state_d.tx = TX_IDLE;
                tx_cnt_d   = '0;
                tx_done    = 1'b1;
            end else tx_cnt_d = tx_cnt + 12'd1;
            default: state_d.tx = TX_IDLE;
        endcase
        case (state_d.tx)
            TX_START: tx_line_d = 1'b0;
            TX_DATA:  tx_line_d = tx_shift_d[0];
            default:  tx_line_d = 1'b1;
        endcase
`ifdef LINK_UART_RX_EN
        rx_cnt_d   = rx_cnt;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_push    = 1'b0;
        case (state_q.rx)
            // The edge-detect cycle counts as 0, so entry starts at 1 and the start sample
            // lands BAUD_DIV/2 cycles after the edge was seen.
            RX_IDLE: if (rx_d && !rx_s2) begin
                state_d.rx = RX_START;
                rx_cnt_d   = 12'd1;
            end
            RX_START: if (rx_cnt == HALF) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                state_d.rx = rx_s2 ? RX_IDLE : RX_DATA;
            end else rx_cnt_d = rx_cnt + 12'd1;
            RX_DATA: if (rx_cnt == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s2, rx_shift[7:1]};
                if (rx_bit == 3'd7) state_d.rx = RX_STOP;
                else rx_bit_d = rx_bit + 3'd1;
            end else rx_cnt_d = rx_cnt + 12'd1;
            RX_STOP: if (rx_cnt == BIT_LAST) begin
                state_d.rx = RX_IDLE;
                rx_cnt_d   = '0;
                rx_push    = rx_s2;
            end else rx_cnt_d = rx_cnt + 12'd1;
            default: state_d.rx = RX_IDLE;
        endcase
`endif
    end

    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            state_q.tx <= TX_IDLE;
            tx_data    <= '0;
            tx_shift   <= '0;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_line    <= 1'b1;
            irq        <= 1'b0;
`ifdef LINK_UART_RX_EN
            state_q.rx <= RX_IDLE;
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_d       <= 1'b1;
            load_d     <= 1'b0;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rx_count   <= '0;
            overrun    <= 1'b0;
`endif
        end else begin
            state_q.tx <= state_d.tx;
            tx_shift   <= tx_shift_d;
            tx_cnt     <= tx_cnt_d;
            tx_bit     <= tx_bit_d;
            tx_line    <= tx_line_d;
            irq        <= irq_d;
            if (sb_wr) tx_data <= indata;
`ifdef LINK_UART_RX_EN
            state_q.rx <= state_d.rx;
            rx_s1      <= UART_RX;
            rx_s2      <= rx_s1;
            rx_d       <= rx_s2;
            load_d     <= load;
            rx_cnt     <= rx_cnt_d;
            rx_bit     <= rx_bit_d;
            rx_shift   <= rx_shift_d;
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop) rx_count <= rx_count + CW'(1);
            else if (pop && !push_ok) rx_count <= rx_count - CW'(1);
            if (ovr_set) overrun <= 1'b1;
            else if (sc_wr) overrun <= 1'b0;
`endif
        end
    end

`ifdef LINK_UART_RX_EN
    always_ff @(posedge clockgb) begin
        if (push_ok) rx_mem[wr_ptr] <= rx_shift_d;
    end
`endif

    always_comb begin
        outdata = 8'h00;
        if (load && sel_sc) begin
`ifdef LINK_UART_RX_EN
            outdata = {busy, 4'b0000, overrun, rx_avail, 1'b0};
`else
            outdata = {busy, 7'b0000000};
`endif
        end else if (load && sel_sb) begin
`ifdef LINK_UART_RX_EN
            outdata = rx_avail ? rx_mem[rd_ptr] : tx_data;
`else
            outdata = tx_data;
`endif
        end
    end
endmodule

// File: tb/tb_link_uart.sv
// Bench for link_uart: register table, framed TX/RX against a byte-level model, reset corners.
module tb_link_uart;
    localparam int BD    = 4;
    localparam int DEPTH = 4;
    localparam int OP_RD = 0;
    localparam int OP_WR = 1;
    localparam int OP_PK = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  indata = 8'h00;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic        uart_rx = 1'b1;
    logic [7:0]  outdata;
    logic        uart_tx;
    logic        irq;

    int          checks = 0;
    int          failures = 0;
    int          irq_count = 0;
    logic [7:0]  model_tx = 8'h00;
    logic [7:0]  exp_q [$];

    typedef struct {
        int          op;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp;
    } vec_t;
    vec_t tbl [18];

    link_uart #(.BAUD_DIV(BD), .RX_DEPTH(DEPTH)) dut (
        .clockgb(clk), .resetn(rst_n), .address(address), .indata(indata),
        .outdata(outdata), .load(load), .store(store), .UART_RX(uart_rx),
        .UART_TX(uart_tx), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (irq === 1'b1) irq_count++;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a; indata = d; store = 1'b1; load = 1'b0;
        if (a == 16'hFF01) model_tx = d;
        @(negedge clk);
        store = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        address = a; load = 1'b1; store = 1'b0;
        #1 d = outdata;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(name, 16'(d), 16'(exp));
    endtask

    // Starts a frame from model_tx and checks the line cycle by cycle, SC busy and the irq pulse.
    task automatic tx_frame(input bit disturb);
        logic [9:0]  frame;
        logic [15:0] na;
        logic [7:0]  nd;
        int          j;
        frame = {1'b1, model_tx, 1'b0};
        j  = disturb ? int'($urandom_range(1, 10 * BD - 3)) : -1;
        na = ($urandom_range(0, 1) == 1) ? 16'hFF01 : 16'hFF02;
        nd = 8'($urandom_range(0, 255));
        @(negedge clk);
        address = 16'hFF02; indata = 8'h80 | 8'($urandom_range(0, 127)); store = 1'b1; load = 1'b0;
        for (int k = 0; k <= 10 * BD + 1; k++) begin
            @(negedge clk);
            store = 1'b0; load = 1'b0;
            if (k == j) begin
                address = na; store = 1'b1;
                indata = (na == 16'hFF02) ? (nd | 8'h80) : nd;
                if (na == 16'hFF01) model_tx = nd;
            end else begin
                address = 16'hFF02; load = 1'b1;
            end
            #1;
            if (k < 10 * BD) begin
                check($sformatf("tx_bit_k%0d", k), 16'(uart_tx), 16'(frame[k / BD]));
                check("tx_irq_low", 16'(irq), 16'h0);
                if (k != j) check("tx_sc_busy", 16'(outdata), 16'h80);
            end else if (k == 10 * BD) begin
                check("tx_irq_pulse", 16'(irq), 16'h1);
                check("tx_line_idle", 16'(uart_tx), 16'h1);
                check("tx_sc_done", 16'(outdata), 16'h00);
            end else begin
                check("tx_irq_once", 16'(irq), 16'h0);
            end
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rx = f[i];
            repeat (BD - 1) @(negedge clk);
        end
        @(negedge clk);
        uart_rx = 1'b1;
    endtask

    initial begin
        int          base;
        logic [7:0]  b;
        logic [9:0]  frame;

        tbl = '{
            '{OP_RD, 16'hFF01, 8'h00, 8'h00}, '{OP_RD, 16'hFF02, 8'h00, 8'h00},
            '{OP_RD, 16'hFF00, 8'h00, 8'h00}, '{OP_RD, 16'hFF03, 8'h00, 8'h00},
            '{OP_PK, 16'hFF01, 8'h00, 8'h00}, '{OP_WR, 16'hFF01, 8'h5A, 8'h00},
            '{OP_RD, 16'hFF01, 8'h00, 8'h5A}, '{OP_PK, 16'hFF01, 8'h00, 8'h00},
            '{OP_RD, 16'hFF02, 8'h00, 8'h00}, '{OP_RD, 16'h0001, 8'h00, 8'h00},
            '{OP_WR, 16'hFF02, 8'h7F, 8'h00}, '{OP_RD, 16'hFF02, 8'h00, 8'h00},
            '{OP_WR, 16'hFF03, 8'h80, 8'h00}, '{OP_RD, 16'hFF02, 8'h00, 8'h00},
            '{OP_WR, 16'hFE01, 8'h33, 8'h00}, '{OP_RD, 16'hFF01, 8'h00, 8'h5A},
            '{OP_PK, 16'hFF02, 8'h00, 8'h00}, '{OP_RD, 16'hFF01, 8'h00, 8'h5A}
        };

        // Reset
        idle(3);
        check("rst_tx_high", 16'(uart_tx), 16'h1);
        check("rst_irq_low", 16'(irq), 16'h0);
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        // Register map table
        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_RD: read_check($sformatf("tbl%0d_read", i), tbl[i].addr, tbl[i].exp);
                OP_WR: begin
                    bus_write(tbl[i].addr, tbl[i].data);
                    #1 check($sformatf("tbl%0d_line", i), 16'(uart_tx), 16'h1);
                end
                default: begin
                    @(negedge clk);
                    address = tbl[i].addr; load = 1'b0;
                    #1 check($sformatf("tbl%0d_peek", i), 16'(outdata), 16'h00);
                end
            endcase
        end

        // Directed A5 frame
        bus_write(16'hFF01, 8'hA5);
        tx_frame(1'b0);
        read_check("a5_sc_after", 16'hFF02, 8'h00);

        // Random frames with mid-frame SB/SC writes
        for (int n = 0; n < 8; n++) begin
            if ($urandom_range(0, 3) != 0) bus_write(16'hFF01, 8'($urandom_range(0, 255)));
            tx_frame(1'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 3)));
        end
        read_check("sb_tx_data", 16'hFF01, model_tx);

`ifdef LINK_UART_RX_EN
        // Single received byte
        base = irq_count;
        rx_send(8'h3C, 1'b1);
        idle(2);
        check("rx3c_irq", 16'(irq_count - base), 16'd1);
        read_check("rx3c_sc", 16'hFF02, 8'h02);
        read_check("rx3c_sb", 16'hFF01, 8'h3C);
        read_check("rx3c_sc_empty", 16'hFF02, 8'h00);

        // Overflow of a DEPTH-entry FIFO
        base = irq_count;
        for (int i = 1; i <= 5; i++) rx_send(8'(i), 1'b1);
        idle(2);
        check("ovr_irqs", 16'(irq_count - base), 16'd4);
        read_check("ovr_sc", 16'hFF02, 8'h06);
        for (int i = 1; i <= 4; i++) read_check($sformatf("ovr_sb%0d", i), 16'hFF01, 8'(i));
        read_check("ovr_sc_drained", 16'hFF02, 8'h04);
        read_check("ovr_sb_txdata", 16'hFF01, model_tx);
        bus_write(16'hFF02, 8'h00);
        read_check("ovr_sc_cleared", 16'hFF02, 8'h00);

        // Glitch and framing error
        base = irq_count;
        @(negedge clk) uart_rx = 1'b0;
        @(negedge clk) uart_rx = 1'b1;
        idle(3 * BD);
        check("glitch_irq", 16'(irq_count - base), 16'd0);
        read_check("glitch_sc", 16'hFF02, 8'h00);
        rx_send(8'h55, 1'b0);
        idle(2 * BD);
        check("frame_err_irq", 16'(irq_count - base), 16'd0);
        read_check("frame_err_sc", 16'hFF02, 8'h00);

        // Random batches against a queue model of the FIFO
        for (int n = 0; n < 6; n++) begin
            int  want_irq;
            bit  ovr;
            exp_q.delete();
            want_irq = 0; ovr = 1'b0;
            base = irq_count;
            for (int m = int'($urandom_range(1, 6)); m > 0; m--) begin
                bit good;
                b = 8'($urandom_range(0, 255));
                good = ($urandom_range(0, 4) != 0);
                rx_send(b, good);
                if (good) begin
                    if (exp_q.size() < DEPTH) begin
                        exp_q.push_back(b);
                        want_irq++;
                    end else ovr = 1'b1;
                end
                idle(int'($urandom_range(0, 2)));
            end
            idle(2);
            check("rnd_irqs", 16'(irq_count - base), 16'(want_irq));
            read_check("rnd_sc", 16'hFF02, {5'b00000, ovr, exp_q.size() != 0, 1'b0});
            while (exp_q.size() != 0) read_check("rnd_sb", 16'hFF01, exp_q.pop_front());
            bus_write(16'hFF02, 8'h00);
            read_check("rnd_sc_end", 16'hFF02, 8'h00);
        end

        // Reset in the middle of a received frame
        base = irq_count;
        fork
            rx_send(8'hFF, 1'b1);
            begin
                idle(5 * BD);
                rst_n = 1'b0;
                idle(2);
                rst_n = 1'b1;
            end
        join
        model_tx = 8'h00;
        idle(2 * BD);
        check("rxrst_irq", 16'(irq_count - base), 16'd0);
        read_check("rxrst_sc", 16'hFF02, 8'h00);
        read_check("rxrst_sb", 16'hFF01, 8'h00);
        rx_send(8'hA7, 1'b1);
        idle(2);
        read_check("rxrst_next_sb", 16'hFF01, 8'hA7);
`else
        // Receiver absent: serial input has no effect
        bus_write(16'hFF01, 8'h12);
        base = irq_count;
        rx_send(8'hFF, 1'b1);
        rx_send(8'($urandom_range(0, 255)), 1'b1);
        idle(2 * BD);
        check("norx_irq", 16'(irq_count - base), 16'd0);
        read_check("norx_sb", 16'hFF01, 8'h12);
        read_check("norx_sc", 16'hFF02, 8'h00);
`endif

        // Reset during data bit 3 of a transmit frame
        bus_write(16'hFF01, 8'($urandom_range(0, 255)) & 8'hF7);
        frame = {1'b1, model_tx, 1'b0};
        @(negedge clk);
        address = 16'hFF02; indata = 8'h80; store = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            store = 1'b0;
        end
        #1 check("txrst_before", 16'(uart_tx), 16'(frame[17 / BD]));
        #1 rst_n = 1'b0;
        #1 check("txrst_line_async", 16'(uart_tx), 16'h1);
        check("txrst_irq", 16'(irq), 16'h0);
        idle(2);
        rst_n = 1'b1;
        model_tx = 8'h00;
        base = irq_count;
        for (int k = 0; k < 20 * BD; k++) begin
            @(negedge clk);
            #1 check("txrst_stay_idle", 16'(uart_tx), 16'h1);
        end
        check("txrst_no_irq", 16'(irq_count - base), 16'd0);
        read_check("txrst_sc", 16'hFF02, 8'h00);
        read_check("txrst_sb", 16'hFF01, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/link_uart.md
LINK_UART -- requirements
Module: link_uart

Interface
REQ-001 Parameter BAUD_DIV, default 36, clockgb cycles per UART bit; legal range 4..4095.
REQ-002 Parameter RX_DEPTH, default 4, RX FIFO entries; power of two, 2..16.
REQ-003 clockgb  in  1  sole clock; all state on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 address  in  16  CPU bus address.
REQ-006 indata  in  8  CPU write data.
REQ-007 outdata  out  8  CPU read data; 8'h00 when not selected (OR-combined bus).
REQ-008 load  in  1  CPU read strobe.
REQ-009 store  in  1  CPU write strobe, one clockgb cycle per write.
REQ-010 UART_RX  in  1  asynchronous serial input, idle high.
REQ-011 UART_TX  out  1  serial output, idle high.
REQ-012 irq  out  1  serial interrupt, one-cycle high pulse.

Function
REQ-013 Register map: 16'hFF01 SB (data), 16'hFF02 SC (control/status); other addresses leave outdata 0 and state unchanged.
REQ-014 outdata combinational: address match and load high -> register value, else 8'h00.
REQ-015 SB write (store at FF01) loads tx_data at any time, including while busy.
REQ-016 SB read: RX FIFO head when FIFO non-empty, else tx_data.
REQ-017 FIFO pop: exactly once per load rising edge (load high, previous-cycle load low) at FF01 with FIFO non-empty.
REQ-018 SC read: bit7 = busy, bit2 = overrun, bit1 = rx_avail (FIFO non-empty), other bits 0.
REQ-019 SC write with indata[7]=1 while idle starts a frame: tx_data copied to shift register, busy = 1 next cycle.
REQ-020 SC write with indata[7]=1 while busy is ignored for bit7; any SC write clears overrun.
REQ-021 TX states IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE; each bit held exactly BAUD_DIV cycles.
REQ-022 UART_TX low from the cycle after the starting SC write; whole frame 10*BAUD_DIV cycles.
REQ-023 At STOP end: busy clears, irq pulses one cycle, TX returns to IDLE.
REQ-024 UART_RX passes a 2-flop synchroniser before any use.
REQ-025 RX states IDLE -> START -> DATA -> STOP; synchronised falling edge in IDLE enters START.
REQ-026 START samples at BAUD_DIV/2 (integer divide); high -> false start, back to IDLE, no push.
REQ-027 Data bits sampled every BAUD_DIV cycles after the start sample, LSB first.
REQ-028 Stop sample low -> framing error: byte discarded, no irq, RX returns to IDLE.
REQ-029 Stop sample high: byte pushed and irq pulses; if FIFO full, byte dropped and overrun set, no irq.
REQ-030 Push and pop in the same cycle: both performed, count unchanged; full FIFO plus pop accepts the push.
REQ-031 FIFO pointers wrap modulo RX_DEPTH; count width clog2(RX_DEPTH)+1.
REQ-032 TX and RX completing in the same cycle: a single irq pulse.
REQ-033 TX and RX run fully independently (full duplex).

Reset
REQ-034 resetn low asynchronously forces UART_TX = 1, irq = 0, busy = 0, overrun = 0, tx_data = 8'h00, FIFO empty, both FSMs IDLE, baud counters 0, synchroniser flops 1.
REQ-035 Reset mid-frame aborts it with no partial push and no irq after release.
REQ-036 After release, first frame starts only on a new SC write; RX needs a fresh falling edge.

Configuration
REQ-037 Macro LINK_UART_RX_EN defined: receiver, FIFO, rx_avail and overrun present as specified.
REQ-038 Macro undefined: no RX logic; UART_RX ignored; SB reads tx_data; SC bits 2:1 read 0; irq from TX completion only.

Verification
REQ-039 BAUD_DIV=4: write SB=8'hA5, SC=8'h80 -> UART_TX 0,1,0,1,0,0,1,0,1,1 over 40 cycles, 4 cycles each; SC bit7 = 1 throughout; irq pulse at end; SC then reads 8'h00.
REQ-040 Inject 8'h3C frame on UART_RX at BAUD_DIV=4 -> irq pulse, SC bit1 = 1, SB read = 8'h3C, bit1 = 0 after the load edge.
REQ-041 RX_DEPTH=4: send 5 bytes 8'h01..8'h05, no reads -> 4 irqs, SC = 8'h06; reads give 01,02,03,04; SC write 8'h00 -> SC = 8'h00.
REQ-042 UART_RX low for 1 cycle only (glitch) -> no push, no irq; stop bit driven low -> byte discarded, no irq.
REQ-043 resetn low at bit 3 of a TX frame -> UART_TX = 1 same cycle; after release stays high 20*BAUD_DIV cycles without an SC write.
REQ-044 LINK_UART_RX_EN undefined: RX frame 8'hFF with SB=8'h12 -> no irq, SB reads 8'h12, SC bits 2:1 = 0.
